// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline stages: fetch FSM encoding and
// instruction/PC constants.
package arm_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } if_state_e;

  localparam logic [31:0] NOP_INSTR = 32'd0;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Redirect targets are word aligned; the two low address bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Generic inter-stage pipeline register: flush inserts a bubble, load captures
// a new instruction/PC pair, otherwise the contents are held.
module if_id_reg
  import arm_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         flush,
  input  logic [W-1:0] instr_in,
  input  logic [W-1:0] pc_in,
  output logic [W-1:0] instr,
  output logic [W-1:0] pc,
  output logic         valid
);

  // Stage register; flush outranks load so a redirect can never leak a word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr <= {W{1'b0}};
      pc    <= {W{1'b0}};
      valid <= 1'b0;
    end else if (flush) begin
      instr <= W'(NOP_INSTR);
      valid <= 1'b0;
    end else if (load) begin
      instr <= instr_in;
      pc    <= pc_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, req/ack fetch FSM with a one-entry
// hold buffer for frozen cycles, and branch redirect with stale-word discard.
module if_stage
  import arm_pkg::*;
#(
  parameter int BIT_NUMBER = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  branch_taken,
  input  logic [BIT_NUMBER-1:0] branch_addr,
  output logic                  imem_req,
  output logic [BIT_NUMBER-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [BIT_NUMBER-1:0] imem_rdata,
  output logic [BIT_NUMBER-1:0] instruction,
  output logic [BIT_NUMBER-1:0] pc,
  output logic                  valid
);

  if_state_e             state_r, state_s;
  logic [BIT_NUMBER-1:0] pc_r, pc_s, redirect_r, redirect_s;
  logic [BIT_NUMBER-1:0] hold_instr_r, hold_instr_s, hold_pc_r, hold_pc_s;
  logic [BIT_NUMBER-1:0] pc_plus_s, target_s, ifid_instr_s, ifid_pc_s;
  logic                  req_r, ack_s, ifid_load_s, ifid_flush_s;

  assign imem_req  = req_r;
  assign imem_addr = pc_r;
  assign ack_s     = imem_ack & req_r;
  assign pc_plus_s = pc_r + BIT_NUMBER'(PC_STEP);
  assign target_s  = BIT_NUMBER'(word_align(32'(branch_addr)));

  // Next-state, PC update and IF/ID control for the fetch FSM.
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    redirect_s   = redirect_r;
    hold_instr_s = hold_instr_r;
    hold_pc_s    = hold_pc_r;
    ifid_load_s  = 1'b0;
    ifid_flush_s = 1'b0;
    ifid_instr_s = imem_rdata;
    ifid_pc_s    = pc_plus_s;
    case (state_r)
      FETCH: begin
        if (branch_taken) begin
          ifid_flush_s = 1'b1;
          if (ack_s) begin
            pc_s = target_s;
          end else begin
            redirect_s = target_s;
            state_s    = DROP;
          end
        end else if (ack_s) begin
          pc_s = pc_plus_s;
          if (freeze) begin
            hold_instr_s = imem_rdata;
            hold_pc_s    = pc_plus_s;
            state_s      = HOLD;
          end else begin
            ifid_load_s = 1'b1;
          end
        end else if (!freeze) begin
          ifid_flush_s = 1'b1;
        end else begin
          ifid_load_s = 1'b0;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          ifid_flush_s = 1'b1;
          hold_instr_s = {BIT_NUMBER{1'b0}};
          hold_pc_s    = {BIT_NUMBER{1'b0}};
          pc_s         = target_s;
          state_s      = FETCH;
        end else if (!freeze) begin
          ifid_load_s  = 1'b1;
          ifid_instr_s = hold_instr_r;
          ifid_pc_s    = hold_pc_r;
          state_s      = FETCH;
        end else begin
          ifid_load_s = 1'b0;
        end
      end
      DROP: begin
        ifid_flush_s = branch_taken | ~freeze;
        if (ack_s) begin
          pc_s    = branch_taken ? target_s : redirect_r;
          state_s = FETCH;
        end else if (branch_taken) begin
          redirect_s = target_s;
        end else begin
          redirect_s = redirect_r;
        end
      end
      default: begin
        state_s = FETCH;
      end
    endcase
  end

  // FSM, PC, redirect, hold buffer and request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= FETCH;
      pc_r         <= {BIT_NUMBER{1'b0}};
      redirect_r   <= {BIT_NUMBER{1'b0}};
      hold_instr_r <= {BIT_NUMBER{1'b0}};
      hold_pc_r    <= {BIT_NUMBER{1'b0}};
      req_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      redirect_r   <= redirect_s;
      hold_instr_r <= hold_instr_s;
      hold_pc_r    <= hold_pc_s;
      req_r        <= (state_s != HOLD);
    end
  end

  if_id_reg #(.W(BIT_NUMBER)) u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (ifid_load_s),
    .flush    (ifid_flush_s),
    .instr_in (ifid_instr_s),
    .pc_in    (ifid_pc_s),
    .instr    (instruction),
    .pc       (pc),
    .valid    (valid)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: memory model returns the fetch address as data
// with a programmable ack latency; all results are hand-computed constants.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'd0;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata, instruction, pc;
  logic        valid;

  int n_cmp = 0;
  int n_err = 0;
  int lat = 0;
  int wait_cnt = 0;

  if_stage #(.BIT_NUMBER(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instruction  (instruction),
    .pc           (pc),
    .valid        (valid)
  );

  always #5 clk = ~clk;

  assign imem_ack   = imem_req && (wait_cnt >= lat);
  assign imem_rdata = imem_addr;

  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_instr", instruction, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    rst = 1'b0;
    tick();
    chk("start_req", {31'd0, imem_req}, 32'd1);
    chk("start_addr", imem_addr, 32'd0);

    // Zero-wait streaming
    tick();
    chk("zw0_instr", instruction, 32'h0);
    chk("zw0_pc", pc, 32'h4);
    chk("zw0_valid", {31'd0, valid}, 32'd1);
    chk("zw0_addr", imem_addr, 32'h4);
    tick();
    chk("zw1_instr", instruction, 32'h4);
    chk("zw1_pc", pc, 32'h8);
    chk("zw1_valid", {31'd0, valid}, 32'd1);
    chk("zw1_addr", imem_addr, 32'h8);

    // Two-cycle ack latency: valid 0,0,1 with stable address
    lat = 2;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) begin
        tick();
        chk("lat_valid", {31'd0, valid}, (k == 2) ? 32'd1 : 32'd0);
        if (k < 2) begin
          chk("lat_addr_stable", imem_addr, 32'h8 + 32'(4 * r));
        end else begin
          chk("lat_instr", instruction, 32'h8 + 32'(4 * r));
          chk("lat_pc", pc, 32'hC + 32'(4 * r));
        end
      end
    end

    // Freeze while the word at 0x8 acks
    lat = 0;
    do_reset();
    tick();
    tick();
    chk("frz_pre_addr", imem_addr, 32'h8);
    freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("frz_instr", instruction, 32'h4);
      chk("frz_pc", pc, 32'h8);
      chk("frz_valid", {31'd0, valid}, 32'd1);
      chk("frz_req", {31'd0, imem_req}, 32'd0);
    end
    freeze = 1'b0;
    tick();
    chk("unfrz_instr", instruction, 32'h8);
    chk("unfrz_pc", pc, 32'hC);
    chk("unfrz_valid", {31'd0, valid}, 32'd1);
    chk("unfrz_req", {31'd0, imem_req}, 32'd1);
    chk("unfrz_addr", imem_addr, 32'hC);
    tick();
    chk("post_instr", instruction, 32'hC);
    chk("post_addr", imem_addr, 32'h10);

    // Branch while ack is two cycles away: stale word at 0x10 dropped
    lat = 2;
    branch_taken = 1'b1;
    branch_addr  = 32'h103;
    tick();
    branch_taken = 1'b0;
    chk("br_bubble_valid", {31'd0, valid}, 32'd0);
    chk("br_bubble_instr", instruction, 32'd0);
    chk("br_stale_addr", imem_addr, 32'h10);
    tick();
    chk("drop_valid", {31'd0, valid}, 32'd0);
    chk("drop_addr", imem_addr, 32'h10);
    tick();
    chk("drop_done_valid", {31'd0, valid}, 32'd0);
    chk("redir_addr", imem_addr, 32'h100);
    tick();
    chk("redir_wait0", {31'd0, valid}, 32'd0);
    tick();
    chk("redir_wait1", {31'd0, valid}, 32'd0);
    tick();
    chk("redir_valid", {31'd0, valid}, 32'd1);
    chk("redir_instr", instruction, 32'h100);
    chk("redir_pc", pc, 32'h104);

    // Branch together with freeze while in HOLD
    lat = 0;
    freeze = 1'b1;
    tick();
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    chk("hold_instr", instruction, 32'h100);
    branch_taken = 1'b1;
    branch_addr  = 32'h200;
    tick();
    branch_taken = 1'b0;
    freeze = 1'b0;
    chk("hbr_valid", {31'd0, valid}, 32'd0);
    chk("hbr_instr", instruction, 32'd0);
    chk("hbr_req", {31'd0, imem_req}, 32'd1);
    chk("hbr_addr", imem_addr, 32'h200);
    tick();
    chk("hbr_first_instr", instruction, 32'h200);
    chk("hbr_first_valid", {31'd0, valid}, 32'd1);

    // PC wrap from 0xFFFFFFFC
    branch_taken = 1'b1;
    branch_addr  = 32'hFFFF_FFFF;
    tick();
    branch_taken = 1'b0;
    chk("wrap_bubble", {31'd0, valid}, 32'd0);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_instr", instruction, 32'hFFFF_FFFC);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_valid", {31'd0, valid}, 32'd1);
    chk("wrap_next_addr", imem_addr, 32'h0);

    // Asynchronous reset mid-operation
    tick();
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, valid}, 32'd0);
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_addr", imem_addr, 32'd0);
    chk("arst_instr", instruction, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage ARM pipeline, i.e. the producer side of the instruction word consumed by `ID_stage`. Holds the PC, fetches words from an instruction memory over a req/ack handshake, and drives the IF/ID pipeline register. It also honours the hazard freeze and redirects on branches taken in EXE, discarding any in-flight or buffered wrong-path word.

## Interface
- `BIT_NUMBER`, 32, data/address width.
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `freeze`  in  1  hazard stall from the hazard unit; holds the IF/ID register.
- `branch_taken`  in  1  redirect request from EXE.
- `branch_addr`  in  BIT_NUMBER  redirect target; bits [1:0] are ignored (forced to 0).
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  BIT_NUMBER  fetch address, word aligned; stable while `imem_req`=1.
- `imem_ack`  in  1  memory response; meaningful only while `imem_req`=1.
- `imem_rdata`  in  BIT_NUMBER  instruction word, valid with `imem_ack`.
- `instruction`  out  BIT_NUMBER  IF/ID instruction to ID.
- `pc`  out  BIT_NUMBER  IF/ID PC, equal to fetch address + 4.
- `valid`  out  1  IF/ID holds a real instruction.

## Operation
- Registers:
  - `pc_q` holds the next fetch address.
  - The hold buffer stores `hold_instr` and `hold_pc`.
  - The IF/ID register holds `instruction`, `pc` and `valid`.
- Reset values: `pc_q`=0, `instruction`=0, `pc`=0, `valid`=0, `imem_req`=0, hold buffer=0, state FETCH.
- `imem_addr` = `pc_q` at all times.
- FSM states:
  - FETCH: `imem_req`=1.
    - On `imem_ack`: the word is captured and `pc_q` += 4.
      - With `freeze`=0, the word loads into IF/ID with `valid`=1 and the state stays FETCH.
      - With `freeze`=1, the word goes to the hold buffer and the state moves to HOLD.
    - No `imem_ack` and `freeze`=0: IF/ID loads a bubble (`instruction`=0, `valid`=0).
    - No `imem_ack` and `freeze`=1: IF/ID holds.
  - HOLD: `imem_req`=0 and IF/ID holds. When `freeze`=0, the hold buffer loads into IF/ID with `valid`=1 and the state moves to FETCH.
  - DROP: `imem_req`=1 at the stale address. On `imem_ack` the word is discarded, `pc_q` is loaded with the saved redirect target, and the state moves to FETCH.
- Branch rules (`branch_taken`=1); branch has priority over `freeze`:
  - IF/ID is flushed to a bubble.
  - In FETCH with `imem_ack`=1 in the same cycle: the word is discarded, `pc_q` is set to `branch_addr`, and the state stays FETCH.
  - In FETCH with `imem_ack`=0: the request is not aborted. The target is saved in `redirect_q` and the state moves to DROP.
  - In HOLD: the hold buffer is discarded, `pc_q` is set to `branch_addr`, and the state moves to FETCH.
  - In DROP: `redirect_q` is overwritten by the newer `branch_addr`.
- PC arithmetic is modulo 2^BIT_NUMBER: 0xFFFFFFFC + 4 gives 0.

## Timing
- Zero-wait memory (ack in the same cycle as req) gives one instruction per cycle. A word appears on IF/ID outputs on the clock edge that samples its ack.
- An N-cycle memory delay gives N bubbles per instruction.
- Leaving HOLD: the buffered word reaches IF/ID on the first edge with `freeze`=0. `imem_req` reasserts in the following cycle.
- DROP costs exactly the remaining ack latency plus one fetch. A branch never produces a wrong-path `valid`=1.
- Reset asserted mid-operation: all state returns to reset values immediately. Any outstanding memory response is ignored because `imem_req`=0.

## Structure
- Shared package `arm_pkg`:
  - FSM state encoding (FETCH, HOLD, DROP).
  - `NOP_INSTR` = 0.
  - `PC_STEP` = 4.
- Natural sub-module: `if_id_reg`, the IF/ID pipeline register with load, hold and flush controls. It is reusable for the other inter-stage registers.

## Test plan
- Reset, zero-wait memory returning `imem_addr` as data:
  - Expected `imem_addr` sequence: 0, 4, 8.
  - Expected IF/ID outputs: (0, pc 4, valid), (4, pc 8, valid), one per cycle.
- Memory with a 2-cycle ack delay: `valid` pattern 0,0,1 repeats, and `imem_addr` is stable for the whole of each request.
- `freeze`=1 for 3 cycles while the word at 0x8 acks:
  - IF/ID holds the word at 0x4, the FSM enters HOLD, and `imem_req`=0.
  - When `freeze` drops, the word at 0x8 appears with `pc`=0xC.
- `branch_taken` with `branch_addr`=0x103 while an ack is 2 cycles away:
  - IF/ID shows a bubble.
  - The stale word at the old address is dropped.
  - The next `imem_addr` is 0x100, and the first `valid` output is the word at 0x100.
- `branch_taken` and `freeze` together while in HOLD: the buffer is discarded, the next fetch is at the target, and no `valid` output is seen from the old path.
- `pc_q`=0xFFFFFFFC with a zero-wait ack: `pc`=0x0 and the next `imem_addr`=0x0.
